// File: rtl/spi_shift_engine.sv
// Full-duplex SPI master shift engine paced by leading/trailing strobes from a clock generator.
// Optional `SPI_LOOPBACK_EN adds i_loopback, which routes o_mosi back into the RX sampler.
module spi_shift_engine #(
  parameter  int DATA_W    = 8,
  parameter  int MAX_WORDS = 8,
  localparam int WC_W      = $clog2(MAX_WORDS),
  localparam int BC_W      = $clog2(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tx_vd,
  input  logic [DATA_W-1:0] i_tx_parallel,
  input  logic [WC_W-1:0]   i_num_words,
  input  logic              i_cpha,
  input  logic              i_lsb_first,
  input  logic              i_leading_edge,
  input  logic              i_trailing_edge,
  input  logic              i_miso,
`ifdef SPI_LOOPBACK_EN
  input  logic              i_loopback,
`endif
  output logic              o_mosi,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_parallel,
  output logic              o_rx_vd,
  output logic              o_underrun,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WC_W-1:0]   num_q, num_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic              fin_q, fin_d;
  logic              mosi_q, mosi_d;
  logic [DATA_W-1:0] rx_par_q, rx_par_d;
  logic              rx_vd_q, rx_vd_d;
  logic              underrun_q, underrun_d;
  logic              done_q, done_d;

  logic              trail_eff, in_shift, samp_edge, drv_edge;
  logic              word_done, last_word, more_left, samp_bit;
  logic              tx_first, in_first;
  logic [DATA_W-1:0] tx_shifted, in_shifted, rx_next;

  // A trailing strobe coinciding with a leading one is a protocol error and is dropped.
  assign trail_eff = i_trailing_edge & ~i_leading_edge;
  assign in_shift  = (state_q == SHIFT);
  assign samp_edge = in_shift & ~fin_q & (cpha_q ? trail_eff : i_leading_edge);
  assign drv_edge  = in_shift & ~fin_q & (cpha_q ? i_leading_edge : trail_eff);
  assign word_done = samp_edge & (bit_cnt_q == BC_W'(DATA_W - 1));
  assign last_word = (word_cnt_q == num_q);

  assign tx_first   = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
  assign tx_shifted = lsb_q ? {1'b0, tx_sr_q[DATA_W-1:1]} : {tx_sr_q[DATA_W-2:0], 1'b0};
  assign in_first   = i_lsb_first ? i_tx_parallel[0] : i_tx_parallel[DATA_W-1];
  assign in_shifted = i_lsb_first ? {1'b0, i_tx_parallel[DATA_W-1:1]}
                                  : {i_tx_parallel[DATA_W-2:0], 1'b0};
  assign rx_next    = lsb_q ? {samp_bit, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], samp_bit};

`ifdef SPI_LOOPBACK_EN
  logic lb_q;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                          lb_q <= 1'b0;
    else if (state_q == IDLE && i_tx_vd) lb_q <= i_loopback;
  end
  assign samp_bit = lb_q ? mosi_q : i_miso;
`else
  assign samp_bit = i_miso;
`endif

  // A word boundary happening this cycle already claims the next slot (buffer or zero fill).
  assign more_left = (word_done && !last_word)
                   ? (({1'b0, word_cnt_q} + (WC_W+1)'(1)) < {1'b0, num_q})
                   : (word_cnt_q < num_q);
  assign o_tx_ready = (state_q == IDLE) | (in_shift & ~hold_vld_q & ~fin_q & more_left);

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    num_d      = num_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    fin_d      = fin_q;
    mosi_d     = mosi_q;
    rx_par_d   = rx_par_q;
    rx_vd_d    = 1'b0;
    underrun_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_tx_vd) begin
          state_d    = SHIFT;
          num_d      = i_num_words;
          cpha_d     = i_cpha;
          lsb_d      = i_lsb_first;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          hold_vld_d = 1'b0;
          fin_d      = 1'b0;
          rx_sr_d    = '0;
          // CPHA=0 presents the first bit immediately; the register keeps the unsent rest.
          mosi_d     = i_cpha ? 1'b0 : in_first;
          tx_sr_d    = i_cpha ? i_tx_parallel : in_shifted;
        end
      end
      SHIFT: begin
        if (drv_edge) begin
          mosi_d  = tx_first;
          tx_sr_d = tx_shifted;
        end
        if (samp_edge) begin
          rx_sr_d   = rx_next;
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (word_done) begin
            bit_cnt_d = '0;
            rx_par_d  = rx_next;
            rx_vd_d   = 1'b1;
            if (!last_word) begin
              word_cnt_d = word_cnt_q + WC_W'(1);
              hold_vld_d = 1'b0;
              tx_sr_d    = hold_vld_q ? hold_q : '0;
              underrun_d = ~hold_vld_q;
            end else if (cpha_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
              mosi_d  = 1'b0;
            end else begin
              fin_d = 1'b1;
            end
          end
        end
        if (fin_q && trail_eff) begin
          state_d = IDLE;
          fin_d   = 1'b0;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
        end
        if (i_tx_vd && o_tx_ready) begin
          hold_d     = i_tx_parallel;
          hold_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      num_q      <= '0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      fin_q      <= 1'b0;
      mosi_q     <= 1'b0;
      rx_par_q   <= '0;
      rx_vd_q    <= 1'b0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      num_q      <= num_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      fin_q      <= fin_d;
      mosi_q     <= mosi_d;
      rx_par_q   <= rx_par_d;
      rx_vd_q    <= rx_vd_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
    end
  end

  assign o_mosi        = mosi_q;
  assign o_rx_parallel = rx_par_q;
  assign o_rx_vd       = rx_vd_q;
  assign o_underrun    = underrun_q;
  assign o_busy        = (state_q == SHIFT);
  assign o_done        = done_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine (DATA_W=8): CPHA modes, bit order, buffering,
// underrun, reset abort, idle strobes and, with SPI_LOOPBACK_EN, internal loopback.
module tb_spi_shift_engine;
  localparam int DW = 8;
  localparam int MW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_tx_vd;
  logic [DW-1:0] i_tx_parallel;
  logic [2:0]    i_num_words;
  logic          i_cpha, i_lsb_first, i_leading_edge, i_trailing_edge, i_miso;
`ifdef SPI_LOOPBACK_EN
  logic          i_loopback;
`endif
  logic          o_mosi, o_tx_ready, o_rx_vd, o_underrun, o_busy, o_done;
  logic [DW-1:0] o_rx_parallel;

  int checks   = 0;
  int failures = 0;

  spi_shift_engine #(.DATA_W(DW), .MAX_WORDS(MW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tx_vd(i_tx_vd), .i_tx_parallel(i_tx_parallel),
    .i_num_words(i_num_words), .i_cpha(i_cpha), .i_lsb_first(i_lsb_first),
    .i_leading_edge(i_leading_edge), .i_trailing_edge(i_trailing_edge), .i_miso(i_miso),
`ifdef SPI_LOOPBACK_EN
    .i_loopback(i_loopback),
`endif
    .o_mosi(o_mosi), .o_tx_ready(o_tx_ready), .o_rx_parallel(o_rx_parallel),
    .o_rx_vd(o_rx_vd), .o_underrun(o_underrun), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_of(input logic [7:0] w, input int b, input logic lsb);
    return lsb ? w[b] : w[7-b];
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic lead_pulse();
    i_leading_edge = 1'b1;
    tick();
    i_leading_edge = 1'b0;
  endtask

  task automatic trail_pulse();
    i_trailing_edge = 1'b1;
    tick();
    i_trailing_edge = 1'b0;
  endtask

  task automatic start(input logic [7:0] d, input logic [2:0] n, input logic cpha, input logic lsb);
    i_tx_parallel = d;
    i_num_words   = n;
    i_cpha        = cpha;
    i_lsb_first   = lsb;
    i_tx_vd       = 1'b1;
    tick();
    i_tx_vd       = 1'b0;
  endtask

  // CPHA=0 word: o_mosi must already show each bit before its leading (sample) edge.
  task automatic word_c0(input string tag, input logic [7:0] tx, input logic [7:0] rx,
                         input logic lsb, input logic exp_ur, input logic exp_done);
    for (int b = 0; b < 8; b++) begin
      check($sformatf("%s_mosi%0d", tag, b), o_mosi, bit_of(tx, b, lsb));
      i_miso = bit_of(rx, b, lsb);
      lead_pulse();
      if (b == 7) begin
        check({tag, "_rxvd"}, o_rx_vd, 1);
        check({tag, "_rxpar"}, o_rx_parallel, rx);
        check({tag, "_underrun"}, o_underrun, exp_ur);
      end
      trail_pulse();
    end
    check({tag, "_done"}, o_done, exp_done);
  endtask

  // CPHA=1 word: leading drives, trailing samples; simul_b marks a bit whose
  // leading strobe carries a simultaneous (illegal) trailing strobe.
  task automatic word_c1(input string tag, input logic [7:0] tx, input logic [7:0] rx,
                         input logic lsb, input int simul_b, input logic exp_done);
    for (int b = 0; b < 8; b++) begin
      i_leading_edge  = 1'b1;
      i_trailing_edge = (b == simul_b);
      tick();
      i_leading_edge  = 1'b0;
      i_trailing_edge = 1'b0;
      check($sformatf("%s_mosi%0d", tag, b), o_mosi, bit_of(tx, b, lsb));
      i_miso = bit_of(rx, b, lsb);
      trail_pulse();
      if (b == 7) begin
        check({tag, "_rxvd"}, o_rx_vd, 1);
        check({tag, "_rxpar"}, o_rx_parallel, rx);
        check({tag, "_underrun"}, o_underrun, 0);
        check({tag, "_done"}, o_done, exp_done);
      end
    end
  endtask

  initial begin
    i_rst = 1'b0; i_tx_vd = 1'b0; i_tx_parallel = '0; i_num_words = '0;
    i_cpha = 1'b0; i_lsb_first = 1'b0; i_leading_edge = 1'b0; i_trailing_edge = 1'b0;
    i_miso = 1'b0;
`ifdef SPI_LOOPBACK_EN
    i_loopback = 1'b0;
`endif
    repeat (3) tick();
    check("rst_ready", o_tx_ready, 1);
    check("rst_mosi", o_mosi, 0);
    check("rst_busy", o_busy, 0);
    check("rst_rxpar", o_rx_parallel, 0);
    check("rst_pulses", {o_rx_vd, o_underrun, o_done}, 0);
    i_rst = 1'b1;
    tick();

    // Single word, CPHA=0, MSB-first
    start(8'hA5, 3'd0, 1'b0, 1'b0);
    check("t1_busy", o_busy, 1);
    check("t1_ready", o_tx_ready, 0);
    word_c0("t1", 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1);
    check("t1_busy_end", o_busy, 0);
    check("t1_mosi_end", o_mosi, 0);
    tick();
    check("t1_done_pulse", o_done, 0);

    // Three words, CPHA=1, LSB-first, buffered; plus ignored i_tx_vd and simultaneous strobes
    start(8'h01, 3'd2, 1'b1, 1'b1);
    check("t2_ready0", o_tx_ready, 1);
    check("t2_mosi_idle", o_mosi, 0);
    i_tx_parallel = 8'h80; i_tx_vd = 1'b1; tick(); i_tx_vd = 1'b0;
    check("t2_ready_full", o_tx_ready, 0);
    word_c1("t2_w0", 8'h01, 8'h5A, 1'b1, -1, 1'b0);
    check("t2_ready1", o_tx_ready, 1);
    i_tx_parallel = 8'hFF; i_tx_vd = 1'b1; tick(); i_tx_vd = 1'b0;
    check("t2_ready_full2", o_tx_ready, 0);
    i_tx_parallel = 8'h33; i_tx_vd = 1'b1; tick(); i_tx_vd = 1'b0;
    word_c1("t2_w1", 8'h80, 8'hC3, 1'b1, 3, 1'b0);
    word_c1("t2_w2", 8'hFF, 8'h0F, 1'b1, -1, 1'b1);
    check("t2_busy_end", o_busy, 0);

    // Underrun: two words, second withheld
    start(8'hC3, 3'd1, 1'b0, 1'b0);
    check("t3_ready0", o_tx_ready, 1);
    word_c0("t3_w0", 8'hC3, 8'hFF, 1'b0, 1'b1, 1'b0);
    check("t3_ready1", o_tx_ready, 0);
    check("t3_busy", o_busy, 1);
    word_c0("t3_w1", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);

    // Reset mid-transaction after three bits
    start(8'hFF, 3'd0, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      lead_pulse();
      trail_pulse();
    end
    check("t4_mosi_pre", o_mosi, 1);
    i_rst = 1'b0;
    #1;
    check("t4_busy", o_busy, 0);
    check("t4_mosi", o_mosi, 0);
    check("t4_ready", o_tx_ready, 1);
    check("t4_rxpar", o_rx_parallel, 0);
    check("t4_pulses", {o_rx_vd, o_underrun, o_done}, 0);
    tick();
    i_rst = 1'b1;
    tick();
    check("t4_done_after", o_done, 0);

    // Strobes in IDLE are ignored
    lead_pulse();
    trail_pulse();
    check("idle_mosi", o_mosi, 0);
    check("idle_busy", o_busy, 0);
    check("idle_done", o_done, 0);

    // Clean restart after reset
    start(8'hA5, 3'd0, 1'b0, 1'b0);
    word_c0("t4_new", 8'hA5, 8'h5A, 1'b0, 1'b0, 1'b1);

`ifdef SPI_LOOPBACK_EN
    for (int c = 0; c < 2; c++) begin
      i_loopback = 1'b1;
      i_miso     = 1'b0;
      start(8'hBE, 3'd0, c[0], 1'b0);
      i_loopback = 1'b0;
      for (int b = 0; b < 8; b++) begin
        lead_pulse();
        trail_pulse();
      end
      check($sformatf("lb_cpha%0d_rxpar", c), o_rx_parallel, 8'hBE);
      check($sformatf("lb_cpha%0d_busy", c), o_busy, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
